// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU load/store path and the debug/loader port.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; otherwise the CPU wins ties.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic              i_dbg_lock,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dbg_gnt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [15:0]       o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DBG  = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_MAX = 3'(MAX_LOCK);
`ifdef DMEM_ARB_RR_EN
  localparam logic FIXED_PRIO = 1'b0;
`else
  localparam logic FIXED_PRIO = 1'b1;
`endif

  state_t      r_st;
  logic [2:0]  r_lock_cnt;
  logic        r_last;        // 1: debug port was granted last
  logic [15:0] r_stall_cnt;

  logic w_lock_hold;
  logic w_tie_cpu;
  logic w_sel_cpu;
  logic w_sel_dbg;
  logic w_sel_we;
  logic w_gnt;

  always_comb begin
    w_sel_cpu   = 1'b0;
    w_sel_dbg   = 1'b0;
    w_lock_hold = (r_st == ST_DBG) && i_dbg_req && i_dbg_lock && (r_lock_cnt < LOCK_MAX);
    w_tie_cpu   = r_last | FIXED_PRIO;
    if (i_reset) begin
      w_sel_cpu = 1'b0;
      w_sel_dbg = 1'b0;
    end else if (w_lock_hold) begin
      w_sel_dbg = 1'b1;
    end else if (i_cpu_req && !i_dbg_req) begin
      w_sel_cpu = 1'b1;
    end else if (!i_cpu_req && i_dbg_req) begin
      w_sel_dbg = 1'b1;
    end else if (i_cpu_req && i_dbg_req) begin
      w_sel_cpu = w_tie_cpu;
      w_sel_dbg = ~w_tie_cpu;
    end
  end

  assign w_gnt    = w_sel_cpu | w_sel_dbg;
  assign w_sel_we = w_sel_cpu ? i_cpu_we : i_dbg_we;

  assign o_cpu_gnt   = w_sel_cpu;
  assign o_dbg_gnt   = w_sel_dbg;
  assign o_cpu_stall = i_cpu_req & ~w_sel_cpu;
  assign o_mem_addr  = w_sel_cpu ? i_cpu_addr  : (w_sel_dbg ? i_dbg_addr  : '0);
  assign o_mem_wdata = w_sel_cpu ? i_cpu_wdata : (w_sel_dbg ? i_dbg_wdata : '0);
  assign o_mem_we    = w_gnt & w_sel_we;
  assign o_mem_re    = w_gnt & ~w_sel_we;
  assign o_cpu_rdata = w_sel_cpu ? i_mem_rdata : '0;
  assign o_dbg_rdata = w_sel_dbg ? i_mem_rdata : '0;
  assign o_stall_cnt = r_stall_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_st        <= ST_IDLE;
      r_lock_cnt  <= 3'd0;
      r_last      <= 1'b1;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_sel_cpu)      r_st <= ST_CPU;
      else if (w_sel_dbg) r_st <= ST_DBG;
      else                r_st <= ST_IDLE;

      if (w_sel_cpu)      r_last <= 1'b0;
      else if (w_sel_dbg) r_last <= 1'b1;

      // Counts consecutive debug grants; saturates so a lone debug burst can continue.
      if (w_sel_dbg) begin
        if (r_st != ST_DBG)             r_lock_cnt <= 3'd1;
        else if (r_lock_cnt < LOCK_MAX) r_lock_cnt <= r_lock_cnt + 3'd1;
      end else begin
        r_lock_cnt <= 3'd0;
      end

      if (o_cpu_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule
